// File: rtl/banked_ram.sv
// -----------------------------------------------------------------------------
// banked_ram
//   Multi-bank single-port word RAM for the subdivision vertex/face buffers.
//   Each bank is a synchronous single-port array with a 1-cycle read latency
//   and per-byte write enables. Only the addressed bank is enabled per access.
//   A zero-clear engine walks every word of every bank (all banks in parallel)
//   after reset and whenever clr_start is seen while idle. Requests are only
//   accepted when idle.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  request can be accepted this cycle (idle)
//   req_wr     1 = write, 0 = read
//   req_be     byte write enables (bit i covers data[8i+7:8i])
//   req_addr   {bank select, word address within bank}
//   req_wdata  write data
//   rsp_valid  one-cycle pulse per accepted request
//   rsp_wr     response belongs to a write
//   rsp_rdata  read data (0 on write responses, held when rsp_valid=0)
//   clr_start  request a full zero-clear
//   busy       clear engine running
// -----------------------------------------------------------------------------
module banked_ram #(
  parameter  int NUM_BANKS       = 4,
  parameter  int BANK_ADDR_WIDTH = 9,
  parameter  int DATA_WIDTH      = 32,
  localparam int BANK_SEL_W      = $clog2(NUM_BANKS),
  localparam int ADDR_WIDTH      = BANK_SEL_W + BANK_ADDR_WIDTH,
  localparam int BE_W            = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [BE_W-1:0]       req_be,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_wr,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  clr_start,
  output logic                  busy
);

  localparam int DEPTH = 2 ** BANK_ADDR_WIDTH;
  localparam logic [BANK_ADDR_WIDTH-1:0] CLR_LAST = '1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [BANK_ADDR_WIDTH-1:0]    r_clr_cnt;

  logic                          w_accept;
  logic [BANK_SEL_W-1:0]         w_bank_sel;
  logic [BANK_ADDR_WIDTH-1:0]    w_word;

  logic                          r_vld_p0;
  logic                          r_wr_p0;
  logic [BANK_SEL_W-1:0]         r_sel_p0;

  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] w_bank_rdata;
  logic [DATA_WIDTH-1:0]         w_rsp_rdata;

  assign req_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state == ST_CLEAR);
  assign w_accept   = req_valid && req_ready;
  assign w_bank_sel = req_addr[ADDR_WIDTH-1:BANK_ADDR_WIDTH];
  assign w_word     = req_addr[BANK_ADDR_WIDTH-1:0];

  // Control state register and clear counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Counter runs only while clearing; it is parked at 0 when idle so a
      // new clear always starts from word 0. It wraps to 0 after the last word.
      if (r_state == ST_CLEAR) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end else begin
        r_clr_cnt <= '0;
      end
    end
  end

  // clr_start is only looked at in IDLE, so a second request during a clear
  // neither restarts nor extends it.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_CLEAR: if (r_clr_cnt == CLR_LAST) w_state_nxt = ST_IDLE;
      ST_IDLE:  if (clr_start)             w_state_nxt = ST_CLEAR;
      default:                             w_state_nxt = ST_CLEAR;
    endcase
  end

  // Bank array: during a clear every bank writes zero to the counter word;
  // otherwise only the addressed bank sees the request.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic                       w_en;
    logic                       w_we;
    logic [BE_W-1:0]            w_be;
    logic [BANK_ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0]      w_wdata;
    logic [DATA_WIDTH-1:0]      r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]      r_rdata;

    always_comb begin
      w_en    = 1'b0;
      w_we    = 1'b0;
      w_be    = '0;
      w_addr  = '0;
      w_wdata = '0;
      if (r_state == ST_CLEAR) begin
        w_en    = 1'b1;
        w_we    = 1'b1;
        w_be    = '1;
        w_addr  = r_clr_cnt;
        w_wdata = '0;
      end else begin
        w_en    = w_accept && (w_bank_sel == BANK_SEL_W'(b));
        w_we    = req_wr;
        w_be    = req_be;
        w_addr  = w_word;
        w_wdata = req_wdata;
      end
    end

    always_ff @(posedge clk) begin
      if (w_en) begin
        if (w_we) begin
          for (int i = 0; i < BE_W; i++) begin
            if (w_be[i]) r_mem[w_addr][8*i +: 8] <= w_wdata[8*i +: 8];
          end
        end else begin
          r_rdata <= r_mem[w_addr];
        end
      end
    end

    assign w_bank_rdata[b] = r_rdata;
  end

  // ---- stage p0: request accepted, bank access in flight ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p0 <= 1'b0;
      r_wr_p0  <= 1'b0;
    end else begin
      r_vld_p0 <= w_accept;
      r_wr_p0  <= req_wr;
    end
  end

  // Bank select captured at acceptance steers the read data; the live
  // req_addr may already point at another bank by the time data returns.
  always_ff @(posedge clk) begin
    if (w_accept) r_sel_p0 <= w_bank_sel;
  end

  assign w_rsp_rdata = r_wr_p0 ? '0 : w_bank_rdata[r_sel_p0];

  // ---- stage p1: registered response ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_wr    <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= r_vld_p0;
      if (r_vld_p0) begin
        rsp_wr    <= r_wr_p0;
        rsp_rdata <= w_rsp_rdata;
      end
    end
  end

endmodule

// File: tb/tb_banked_ram.sv
module tb_banked_ram;

  localparam int AW        = 11;
  localparam int DW        = 32;
  localparam int BEW       = 4;
  localparam int WORDS_ALL = 2048;
  localparam int CLR_LEN   = 512;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic            req_wr;
  logic [BEW-1:0]  req_be;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic            rsp_valid;
  logic            rsp_wr;
  logic [DW-1:0]   rsp_rdata;
  logic            clr_start;
  logic            busy;

  always #5 clk = ~clk;

  banked_ram #(
    .NUM_BANKS      (4),
    .BANK_ADDR_WIDTH(9),
    .DATA_WIDTH     (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wr   (req_wr),
    .req_be   (req_be),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_wr   (rsp_wr),
    .rsp_rdata(rsp_rdata),
    .clr_start(clr_start),
    .busy     (busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: flat word memory indexed by the full address, a clear
  // countdown, and the one response in flight.
  logic [DW-1:0] m_mem [WORDS_ALL];
  int            clr_left;
  bit            pend_v, pend_wr;
  logic [DW-1:0] pend_d;
  bit            exp_v, exp_wr;
  logic [DW-1:0] exp_d;

  typedef struct {
    bit            v;
    bit            wr;
    logic [3:0]    be;
    logic [10:0]   addr;
    logic [31:0]   wd;
    bit            ev;
    bit            ewr;
    logic [31:0]   ed;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    clr_left = CLR_LEN;
    pend_v = 0; pend_wr = 0; pend_d = '0;
    exp_v = 0; exp_wr = 0; exp_d = '0;
    for (int i = 0; i < WORDS_ALL; i++) m_mem[i] = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " busy"},      busy,      (clr_left > 0));
    chk({tag, " req_ready"}, req_ready, (clr_left == 0));
    chk({tag, " rsp_valid"}, rsp_valid, exp_v);
    chk({tag, " rsp_wr"},    rsp_wr,    exp_wr);
    chk({tag, " rsp_rdata"}, rsp_rdata, exp_d);
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, check #1 later.
  task automatic cycle(input bit v, input bit wr, input logic [3:0] be,
                       input logic [10:0] addr, input logic [31:0] wd,
                       input bit clr, input string tag);
    bit            acc;
    bit            nv, nwr;
    logic [DW-1:0] nd;
    req_valid = v; req_wr = wr; req_be = be; req_addr = addr;
    req_wdata = wd; clr_start = clr;
    acc = v && (clr_left == 0);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      nv = 0; nwr = 0; nd = '0;
      if (acc) begin
        nv = 1;
        nwr = wr;
        if (wr) begin
          for (int i = 0; i < BEW; i++)
            if (be[i]) m_mem[addr][8*i +: 8] = wd[8*i +: 8];
        end else begin
          nd = m_mem[addr];
        end
      end
      exp_v = pend_v;
      if (pend_v) begin
        exp_wr = pend_wr;
        exp_d  = pend_d;
      end
      pend_v = nv; pend_wr = nwr; pend_d = nd;
      if (clr_left > 0) begin
        clr_left--;
      end else if (clr) begin
        clr_left = CLR_LEN;
        for (int i = 0; i < WORDS_ALL; i++) m_mem[i] = '0;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    cycle(0, 0, 4'h0, 11'h000, 32'h0, 0, tag);
  endtask

  // Steps through a clear while poking requests that must be refused.
  // Returns the number of post-step observations with busy=1.
  task automatic run_clear(input int reclr_at, output int n);
    int k;
    n = 0;
    k = 0;
    while (busy && k < 1000) begin
      k++;
      cycle((k % 5) == 0, 0, 4'h0, 11'(k), 32'h0, (k == reclr_at), "clr");
      if (busy) n++;
    end
    chk("clear terminates", busy, 1'b0);
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    req_valid = 0; clr_start = 0;
    #1;
    model_reset();
    chk({tag, " rst busy"},      busy,      1'b1);
    chk({tag, " rst req_ready"}, req_ready, 1'b0);
    chk({tag, " rst rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, " rst rsp_wr"},    rsp_wr,    1'b0);
    chk({tag, " rst rsp_rdata"}, rsp_rdata, 32'h0);
    idle({tag, " in-reset"});
    idle({tag, " in-reset"});
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int total;

    tbl[0]  = '{1, 1, 4'hF, 11'h000, 32'hDEADBEEF, 0, 0, 32'h0};
    tbl[1]  = '{1, 1, 4'hF, 11'h200, 32'hDEADBEEF, 1, 1, 32'h0};
    tbl[2]  = '{1, 1, 4'hF, 11'h400, 32'hDEADBEEF, 1, 1, 32'h0};
    tbl[3]  = '{1, 1, 4'hF, 11'h600, 32'hDEADBEEF, 1, 1, 32'h0};
    tbl[4]  = '{1, 0, 4'h0, 11'h000, 32'h0,        1, 1, 32'h0};
    tbl[5]  = '{1, 0, 4'h0, 11'h200, 32'h0,        1, 0, 32'hDEADBEEF};
    tbl[6]  = '{1, 0, 4'h0, 11'h400, 32'h0,        1, 0, 32'hDEADBEEF};
    tbl[7]  = '{1, 0, 4'h0, 11'h600, 32'h0,        1, 0, 32'hDEADBEEF};
    tbl[8]  = '{1, 1, 4'hF, 11'h123, 32'h11223344, 1, 0, 32'hDEADBEEF};
    tbl[9]  = '{1, 1, 4'h5, 11'h123, 32'hAABBCCDD, 1, 1, 32'h0};
    tbl[10] = '{1, 0, 4'h0, 11'h123, 32'h0,        1, 1, 32'h0};
    tbl[11] = '{1, 1, 4'hF, 11'h010, 32'h00000001, 1, 0, 32'h11BB33DD};
    tbl[12] = '{1, 1, 4'hF, 11'h210, 32'h00000002, 1, 1, 32'h0};
    tbl[13] = '{1, 0, 4'h0, 11'h010, 32'h0,        1, 1, 32'h0};
    tbl[14] = '{1, 0, 4'h0, 11'h210, 32'h0,        1, 0, 32'h00000001};
    tbl[15] = '{1, 1, 4'h0, 11'h010, 32'hFFFFFFFF, 1, 0, 32'h00000002};
    tbl[16] = '{1, 0, 4'h0, 11'h010, 32'h0,        1, 1, 32'h0};
    tbl[17] = '{0, 0, 4'h0, 11'h000, 32'h0,        1, 0, 32'h00000001};
    tbl[18] = '{0, 0, 4'h0, 11'h000, 32'h0,        0, 0, 32'h00000001};

    // Power-on reset and the initial clear
    rst_n = 1'b0;
    req_valid = 0; req_wr = 0; req_be = '0; req_addr = '0; req_wdata = '0;
    clr_start = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("por busy",      busy,      1'b1);
    chk("por req_ready", req_ready, 1'b0);
    chk("por rsp_valid", rsp_valid, 1'b0);
    chk("por rsp_wr",    rsp_wr,    1'b0);
    chk("por rsp_rdata", rsp_rdata, 32'h0);
    rst_n = 1'b1;
    total = busy ? 1 : 0;
    run_clear(0, n);
    chk("por clear length", total + n, CLR_LEN);
    chk("por ready after clear", req_ready, 1'b1);
    repeat (80) idle("idle");

    // Cleared memory reads as zero
    cycle(1, 0, 4'h0, 11'h7FF, 32'h0, 0, "rd7ff");
    idle("rd7ff");
    chk("rd7ff rsp_valid", rsp_valid, 1'b1);
    chk("rd7ff rdata",     rsp_rdata, 32'h0);

    // Directed vector table
    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].v, tbl[i].wr, tbl[i].be, tbl[i].addr, tbl[i].wd, 0, "tbl");
      chk($sformatf("tbl%0d rsp_valid", i), rsp_valid, tbl[i].ev);
      chk($sformatf("tbl%0d rsp_wr", i),    rsp_wr,    tbl[i].ewr);
      chk($sformatf("tbl%0d rsp_rdata", i), rsp_rdata, tbl[i].ed);
    end

    // Random traffic against the reference model, concentrated on a few
    // words per bank so read-after-write and steering cases recur.
    for (int i = 0; i < 400; i++) begin
      logic [10:0] a;
      a = {2'($urandom), 6'h00, 3'($urandom)};
      cycle(($urandom % 4) != 0, $urandom % 2, 4'($urandom), a, $urandom, 0, "rand");
    end
    repeat (2) idle("rand drain");

    // clr_start with a concurrent write; second clr_start mid-clear ignored
    cycle(1, 1, 4'hF, 11'h7FF, 32'h5A5A5A5A, 1, "clrw");
    chk("clrw busy", busy, 1'b1);
    total = 1;
    idle("clrw ack");
    chk("clrw ack valid", rsp_valid, 1'b1);
    chk("clrw ack wr",    rsp_wr,    1'b1);
    if (busy) total++;
    run_clear(100, n);
    chk("clrw clear length", total + n, CLR_LEN);
    cycle(1, 0, 4'h0, 11'h7FF, 32'h0, 0, "clrw rd");
    idle("clrw rd");
    chk("clrw rd valid", rsp_valid, 1'b1);
    chk("clrw rd rdata", rsp_rdata, 32'h0);

    // Reset right after an accept drops the pending response
    cycle(1, 0, 4'h0, 11'h010, 32'h0, 0, "pdrop");
    apply_reset("pdrop");
    total = busy ? 1 : 0;
    run_clear(0, n);
    chk("pdrop clear length", total + n, CLR_LEN);

    // Reset in the middle of a clear restarts it from word 0
    idle("mid");
    cycle(0, 0, 4'h0, 11'h000, 32'h0, 1, "mid start");
    repeat (300) idle("mid");
    apply_reset("mid");
    total = busy ? 1 : 0;
    run_clear(0, n);
    chk("mid clear length", total + n, CLR_LEN);
    chk("mid ready after", req_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/banked_ram.md
Name: banked_ram

Overview:
- Parametrised multi-bank single-port word RAM. Successor to the fixed 4x512x32 quad-bank store used for the subdivision vertex/face buffers.
- Generalised in bank count, bank depth and data width. Adds a valid/ready request handshake, a registered read-bank select for correct data steering, write acknowledges, and a hardware zero-clear engine that runs after reset and on demand.
- Sits between the subdivision datapath and local storage.

Parameters:
- NUM_BANKS, 4, number of banks; power of two, >=2.
- BANK_ADDR_WIDTH, 9, word address width inside one bank (depth = 2^BANK_ADDR_WIDTH).
- DATA_WIDTH, 32, word width; multiple of 8.
- Derived, not overridable: BANK_SEL_W = log2(NUM_BANKS); ADDR_WIDTH = BANK_SEL_W + BANK_ADDR_WIDTH; BE_W = DATA_WIDTH/8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_wr  in  1  1 = write, 0 = read.
- req_be  in  BE_W  byte write enables; bit i covers data[8i+7:8i]; ignored on reads.
- req_addr  in  ADDR_WIDTH  MSBs = bank select, LSBs = word address in bank.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle pulse per accepted request.
- rsp_wr  out  1  response corresponds to a write.
- rsp_rdata  out  DATA_WIDTH  read data; 0 on write responses.
- clr_start  in  1  request a full zero-clear of all banks.
- busy  out  1  clear engine running.

Behaviour:
- Banks: synchronous single-port, 1-cycle read latency, per-byte write enable.
- Only the addressed bank is enabled per access; all other bank enables stay low.
- Handshake:
  - A request is accepted when req_valid && req_ready on a rising edge.
  - req_ready = (state == IDLE); combinational from state only, never from req_valid.
  - One request per cycle; back-to-back accepts are allowed.
- Latency:
  - A request accepted at edge N produces rsp_valid=1 during the cycle after edge N+1, i.e. exactly one cycle later; responses stay in order.
  - rsp_wr echoes req_wr.
  - rsp_rdata comes from the bank selected by the bank select registered at acceptance, not the current req_addr.
  - When rsp_valid=0, rsp_rdata holds its last value.
- Writes:
  - Bytes with req_be bit 0 are unchanged.
  - req_be=0 is a legal no-op write that is still acknowledged.
- Read-after-write to the same address on consecutive accepts returns the new data.
- State machine: CLEAR, IDLE.
  - Reset enters CLEAR with clear counter 0 and busy=1.
  - CLEAR:
    - Each cycle writes all-zero with all byte enables to word counter in every bank simultaneously.
    - The counter increments by 1.
    - When counter = 2^BANK_ADDR_WIDTH-1 is written, the next state is IDLE and busy falls.
    - Clear takes exactly 2^BANK_ADDR_WIDTH cycles (512 at defaults).
  - IDLE:
    - clr_start=1 moves to CLEAR next cycle with counter 0.
    - A request accepted in that same cycle executes first, and its response is still delivered the following cycle.
  - clr_start while in CLEAR is ignored; it does not restart the count.
  - Requests are never accepted in CLEAR (req_ready=0).
- Reset values: req_ready=0, rsp_valid=0, rsp_wr=0, rsp_rdata=0, busy=1.
- Reset asserted mid-operation:
  - Any pending response is dropped.
  - The clear restarts from word 0.
  - Partial clear contents are irrelevant because the full clear reruns.
- Bank selection is exhaustive (power-of-two NUM_BANKS), so no out-of-range address exists.

Test Plan:
- Reset, then idle 600 cycles:
  - busy=1 and req_ready=0 for exactly 512 cycles after rst_n rises.
  - busy=0 and req_ready=1 on the 513th cycle.
  - A read of addr 0x7FF returns 0x00000000.
- Write 0xDEADBEEF be=4'hF to 0x000, 0x200, 0x400, 0x600 back-to-back, then read all four back-to-back:
  - Four consecutive rsp_valid pulses with rsp_wr=1 and rdata=0.
  - Then four reads returning 0xDEADBEEF in order, each one cycle after its accept.
- Write 0x11223344 to 0x123, then write 0xAABBCCDD be=4'b0101 to 0x123, then read 0x123 -> 0x11BB33DD.
- Bank-steer check:
  - Write 0x1 to 0x010 (bank 0) and 0x2 to 0x210 (bank 1).
  - Read 0x010, then immediately read 0x210 on the next cycle.
  - Responses are 0x1 then 0x2; bank-1 data is not seen in the first response.
- clr_start with a concurrent write of 0x5A5A5A5A to 0x7FF:
  - Write acked next cycle.
  - busy=1 for 512 cycles.
  - A second clr_start at clear cycle 100 does not extend the clear.
  - A subsequent read of 0x7FF returns 0.
- Assert rst_n=0 at clear cycle 300:
  - Outputs return to reset values immediately.
  - After release, a full 512-cycle clear runs again before req_ready=1.
